npc_predict_unit: RTL
=====================

// Module: npc_predict_unit
// PURPOSE
//  Registered fetch-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit counters.
//  Predicts the next fetch address each cycle. Redirects on exception, eret, or a D-stage misprediction.
//  Sits at the F stage and replaces the combinational next-PC path. D-stage resolution feeds back via d_*.
// PARAMETERS
//  RESET_PC   32'h0000_3000  fetch address after reset
//  EXC_VEC    32'h0000_4180  exception/interrupt entry address
//  BTB_IDX_W  4              BTB index bits; depth = 2**BTB_IDX_W
//  RAS_DEPTH  4              return-stack entries (used only with NPC_RAS_EN)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-low reset
//  stall          in   1   hold f_pc (F stage stalled)
//  req            in   1   take exception/interrupt
//  d_eret         in   1   eret resolved in D
//  epc            in   32  eret return address, used as-is
//  d_valid        in   1   D holds a real (non-bubble) instruction
//  d_pc           in   32  PC of the D instruction
//  d_br           in   1   D instruction is a branch/jump
//  d_uncond       in   1   D instruction is j/jal/jr/jalr
//  d_taken        in   1   actual direction
//  d_next_pc      in   32  architecturally correct next fetch address after d_pc
//  d_pred_next    in   32  f_pred_next that was carried down with this instruction
//  d_call         in   1   jal/jalr resolved (RAS push)
//  d_ret          in   1   jr $ra resolved (RAS pop)
//  d_link_addr    in   32  return address to push
//  f_pc           out  32  current fetch address (register)
//  f_pred_next    out  32  predicted next fetch address for f_pc (combinational)
//  f_pred_taken   out  1   BTB hit with predicted-taken
//  flush          out  1   redirect this cycle; kill wrong-path F/D contents
// BEHAVIOUR
//  - Reset (reset==0 at posedge): f_pc<=RESET_PC; all BTB valid bits cleared; RAS emptied. Mid-operation reset discards all state.
//  - Lookup: idx = f_pc[BTB_IDX_W+1:2]; tag = f_pc[31:BTB_IDX_W+2]. hit = valid & tag match.
//    f_pred_taken = hit & cnt[1]. f_pred_next = f_pred_taken ? target : f_pc+4.
//  - mispredict = d_valid & (d_next_pc != d_pred_next).
//  - Next f_pc priority (first match wins): req -> EXC_VEC; d_eret -> epc; mispredict -> d_next_pc; stall -> hold; else f_pred_next.
//  - flush = req | d_eret | mispredict (combinational, same cycle). Redirects override stall.
//  - BTB update at posedge when d_valid & d_br, index/tag taken from d_pc:
//    - hit & d_taken: cnt saturating-increment (max 2'b11); target <= d_next_pc.
//    - hit & !d_taken: cnt saturating-decrement (min 2'b00); target kept.
//    - miss & d_taken: allocate (overwrite) entry; cnt = 2'b10 (2'b11 if d_uncond).
//    - miss & !d_taken: no write.
//    - d_uncond entries always hold cnt = 2'b11.
//  - Update uses d_pc; lookup uses f_pc. When both map to the same index in one cycle, lookup sees the pre-update entry (write-first not required).
//  - BTB updates still occur on a req/eret cycle if d_valid is set.
//  - All PC arithmetic is 32-bit modulo 2^32; f_pc+4 wraps at 32'hFFFF_FFFC -> 0.
// CONFIGURATION
//  NPC_RAS_EN defined:
//    - Each BTB entry gains an is_ret bit, set on allocation/update when d_ret.
//    - RAS push at posedge on d_valid&d_call (d_link_addr). Pop on d_valid&d_ret.
//    - When push and pop occur together: pop, then push.
//    - Full stack: push overwrites the oldest entry (circular).
//    - Empty stack: pop is ignored.
//    - Prediction: hit & is_ret & RAS non-empty -> f_pred_next = RAS top, f_pred_taken=1.
//  NPC_RAS_EN undefined: no RAS storage; d_call/d_ret/d_link_addr are ignored; ports remain.
// STRUCTURE
//  Shared package/header (npc_pkg): BTB entry struct {valid, tag, target, cnt[1:0], is_ret}, counter constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3, default RESET_PC/EXC_VEC.
//  One sub-module: npc_ras (circular stack, RAS_DEPTH entries, push/pop/top/empty), instantiated only under NPC_RAS_EN.
//  Top holds the PC register, BTB arrays, and the priority mux.
// TESTING
//  1. Reset low one cycle, then release, stall=0, no d_valid -> f_pc 3000,3004,3008...; f_pred_taken=0; flush=0.
//  2. beq at 3010 -> 3040 resolved taken (d_pred_next=3014) -> flush=1; next f_pc=3040. On the next fetch of 3010: f_pred_next=3040, cnt=2.
//  3. Same beq resolved not-taken twice after cnt=2 -> cnt 1 then 0. The first not-taken resolution flushes to 3014. Afterwards f_pred_next=3014.
//  4. req=1, d_eret=1 and a mispredict in the same cycle, stall=1 -> f_pc=4180; flush=1. Then eret alone with epc=3020 -> f_pc=3020.
//  5. stall=1 for 3 cycles, no redirect -> f_pc held. Deassert stall -> resumes at f_pred_next.
//  6. (NPC_RAS_EN) jal at 3000 (link 3004) then jr $ra resolved once -> later fetch of that jr predicts 3004. Five nested calls with RAS_DEPTH=4 -> oldest entry lost; pops on empty are ignored.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and constants for the fetch-PC predictor: BTB entry layout,
// 2-bit counter encodings and default reset/exception addresses.
package npc_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  // Tag is sized for the smallest index width; narrower tags are zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  cnt;
    logic        is_ret;
  } btb_entry_t;

  function automatic logic [1:0] cnt_update(input logic [1:0] cnt,
                                            input logic taken,
                                            input logic uncond);
    logic [1:0] res;
    if (uncond)     res = CNT_ST;
    else if (taken) res = (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else            res = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
// A simultaneous pop and push is applied as pop first, then push.
module npc_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_addr,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]    mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop_eff;
  logic [PTR_W-1:0] ptr_pop;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   count_pop;

  assign pop_eff   = pop && (count_reg != '0);
  assign ptr_pop   = pop_eff ? ptr_reg - 1'b1 : ptr_reg;
  assign count_pop = count_reg - (PTR_W+1)'(pop_eff);
  assign top_idx   = ptr_reg - 1'b1;
  assign top       = mem[top_idx];
  assign empty     = (count_reg == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      ptr_reg   <= ptr_pop + 1'b1;
      count_reg <= (count_pop == (PTR_W+1)'(DEPTH)) ? count_pop : count_pop + 1'b1;
    end else begin
      ptr_reg   <= ptr_pop;
      count_reg <= count_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[ptr_pop] <= push_addr;
  end

endmodule

// File: rtl/npc_predict_unit.sv
// Registered fetch-PC generator with a direct-mapped BTB and 2-bit counters.
// Optional return-address stack is built only when NPC_RAS_EN is defined.
module npc_predict_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          BTB_IDX_W = 4,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        d_eret,
  input  logic [31:0] epc,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic        d_br,
  input  logic        d_uncond,
  input  logic        d_taken,
  input  logic [31:0] d_next_pc,
  input  logic [31:0] d_pred_next,
  input  logic        d_call,
  input  logic        d_ret,
  input  logic [31:0] d_link_addr,
  output logic [31:0] f_pc,
  output logic [31:0] f_pred_next,
  output logic        f_pred_taken,
  output logic        flush
);

  localparam int DEPTH = 1 << BTB_IDX_W;

  btb_entry_t             btb_mem [DEPTH];
  logic [BTB_IDX_W-1:0]   f_idx;
  logic [BTB_IDX_W-1:0]   d_idx;
  logic [29:0]            f_tag;
  logic [29:0]            d_tag;
  logic                   f_hit;
  logic                   d_hit;
  logic                   ras_hit;
  logic                   ret_bit;
  logic [31:0]            ras_top;
  logic                   mispredict;
  logic [31:0]            pc_next;
  logic [31:0]            seq_pc;
  btb_entry_t             alloc_ent;
  logic                   unused_bits;

  assign f_idx = f_pc[BTB_IDX_W+1:2];
  assign d_idx = d_pc[BTB_IDX_W+1:2];
  assign f_tag = 30'(f_pc[31:BTB_IDX_W+2]);
  assign d_tag = 30'(d_pc[31:BTB_IDX_W+2]);
  assign f_hit = btb_mem[f_idx].valid && (btb_mem[f_idx].tag == f_tag);
  assign d_hit = btb_mem[d_idx].valid && (btb_mem[d_idx].tag == d_tag);
  assign seq_pc = f_pc + 32'd4;
  assign unused_bits = ^d_pc[1:0];

`ifdef NPC_RAS_EN
  logic ras_empty;

  npc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (d_valid && d_call),
    .pop       (d_valid && d_ret),
    .push_addr (d_link_addr),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign ras_hit = f_hit && btb_mem[f_idx].is_ret && !ras_empty;
  assign ret_bit = d_ret;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras;

  assign unused_ras = ^{d_call, d_ret, d_link_addr, btb_mem[f_idx].is_ret};
  assign ras_hit    = 1'b0;
  assign ras_top    = 32'd0;
  assign ret_bit    = 1'b0;
`endif

  // Prediction reads the pre-update entry; no bypass from the D-stage write.
  always_comb begin
    f_pred_taken = (f_hit && btb_mem[f_idx].cnt[1]) || ras_hit;
    if (ras_hit)           f_pred_next = ras_top;
    else if (f_pred_taken) f_pred_next = btb_mem[f_idx].target;
    else                   f_pred_next = seq_pc;
  end

  assign mispredict = d_valid && (d_next_pc != d_pred_next);
  assign flush      = req || d_eret || mispredict;

  always_comb begin
    if (req)             pc_next = EXC_VEC;
    else if (d_eret)     pc_next = epc;
    else if (mispredict) pc_next = d_next_pc;
    else if (stall)      pc_next = f_pc;
    else                 pc_next = f_pred_next;
  end

  always_comb begin
    alloc_ent        = '0;
    alloc_ent.valid  = 1'b1;
    alloc_ent.tag    = d_tag;
    alloc_ent.target = d_next_pc;
    alloc_ent.cnt    = d_uncond ? CNT_ST : CNT_WT;
    alloc_ent.is_ret = ret_bit;
  end

  always_ff @(posedge clk) begin
    if (!reset) f_pc <= RESET_PC;
    else        f_pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) btb_mem[i].valid <= 1'b0;
    end else if (d_valid && d_br) begin
      if (d_hit) begin
        btb_mem[d_idx].cnt    <= cnt_update(btb_mem[d_idx].cnt, d_taken, d_uncond);
        btb_mem[d_idx].is_ret <= ret_bit;
        if (d_taken) btb_mem[d_idx].target <= d_next_pc;
      end else if (d_taken) begin
        btb_mem[d_idx] <= alloc_ent;
      end
    end
  end

endmodule
